// File: rtl/game_ctrl.sv
// game_ctrl: round / lives / score / level controller for the frogger game.
// Frame tick comes from the falling edge of VSYNC, the start press from a
// rising edge on any d-pad button. All outputs are registered.
module game_ctrl #(
    parameter int unsigned START_LIVES     = 3,
    parameter int unsigned DEATH_FRAMES    = 60,
    parameter int unsigned GAMEOVER_FRAMES = 120,
    parameter int unsigned MAX_LEVEL       = 7
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        vsync,
    input  logic        collision,
    input  logic        reached_end,
    input  logic [3:0]  dpad_input,
    output logic [1:0]  state,
    output logic        frog_respawn,
    output logic [1:0]  lives,
    output logic [15:0] score,
    output logic [2:0]  level,
    output logic        flash
);

    // Timer must hold the larger of the two frame counts; bit 3 drives flash,
    // so keep at least four bits.
    localparam int unsigned TIMER_MAX = (DEATH_FRAMES > GAMEOVER_FRAMES) ?
                                        DEATH_FRAMES : GAMEOVER_FRAMES;
    localparam int unsigned TW = ($clog2(TIMER_MAX) < 4) ? 4 : $clog2(TIMER_MAX);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_PLAY     = 2'b01,
        ST_DYING    = 2'b10,
        ST_GAMEOVER = 2'b11
    } state_t;

    // Add ten to a four-digit BCD value: tens digit upward, units untouched.
    function automatic logic [15:0] bcd_add10(input logic [15:0] value);
        logic [15:0] result;
        logic        carry;
        result = value;
        carry  = 1'b1;
        for (int d = 1; d < 4; d++) begin
            if (carry) begin
                if (result[d*4 +: 4] >= 4'd9) begin
                    result[d*4 +: 4] = 4'd0;
                    carry            = 1'b1;
                end else begin
                    result[d*4 +: 4] = result[d*4 +: 4] + 4'd1;
                    carry            = 1'b0;
                end
            end else begin
                carry = 1'b0;
            end
        end
        return result;
    endfunction

    state_t          state_r;
    state_t          state_s;
    logic            vsync_r;
    logic [3:0]      dpad_r;
    logic [TW-1:0]   timer_r;
    logic [TW-1:0]   timer_s;
    logic [1:0]      lives_s;
    logic [15:0]     score_s;
    logic [2:0]      level_s;
    logic            respawn_ev_s;
    logic            respawn_s;
    logic            flash_s;
    logic            frame_tick_s;
    logic            start_edge_s;

    assign frame_tick_s = vsync_r & ~vsync;
    assign start_edge_s = (|dpad_input) & (dpad_r == 4'd0);
    assign state        = state_r;

    // Input edge-detect registers for VSYNC and the d-pad.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_r <= 1'b0;
            dpad_r  <= 4'd0;
        end else begin
            vsync_r <= vsync;
            dpad_r  <= dpad_input;
        end
    end

    // Next-state and next-value logic for the game FSM and its counters.
    always_comb begin
        state_s      = state_r;
        timer_s      = timer_r;
        lives_s      = lives;
        score_s      = score;
        level_s      = level;
        respawn_ev_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_edge_s) begin
                    state_s      = ST_PLAY;
                    lives_s      = 2'(START_LIVES);
                    score_s      = 16'h0000;
                    level_s      = 3'd0;
                    respawn_ev_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (frame_tick_s && collision) begin
                    state_s = ST_DYING;
                    lives_s = (lives == 2'd0) ? 2'd0 : lives - 2'd1;
                    timer_s = TW'(DEATH_FRAMES - 1);
                end else if (frame_tick_s && reached_end) begin
                    score_s      = (score[15:4] == 12'h999) ? score : bcd_add10(score);
                    level_s      = (level >= 3'(MAX_LEVEL)) ? 3'(MAX_LEVEL) : level + 3'd1;
                    respawn_ev_s = 1'b1;
                end else begin
                    state_s = ST_PLAY;
                end
            end
            ST_DYING: begin
                if (frame_tick_s && (timer_r == '0)) begin
                    if (lives == 2'd0) begin
                        state_s = ST_GAMEOVER;
                        timer_s = TW'(GAMEOVER_FRAMES - 1);
                    end else begin
                        state_s      = ST_PLAY;
                        respawn_ev_s = 1'b1;
                    end
                end else if (frame_tick_s) begin
                    timer_s = timer_r - TW'(1);
                end else begin
                    state_s = ST_DYING;
                end
            end
            ST_GAMEOVER: begin
                if (start_edge_s && (timer_r == '0)) begin
                    state_s      = ST_PLAY;
                    lives_s      = 2'(START_LIVES);
                    score_s      = 16'h0000;
                    level_s      = 3'd0;
                    respawn_ev_s = 1'b1;
                end else if (frame_tick_s && (timer_r != '0)) begin
                    timer_s = timer_r - TW'(1);
                end else begin
                    state_s = ST_GAMEOVER;
                end
            end
            default: begin
                state_s = ST_IDLE;
                timer_s = '0;
            end
        endcase
        // A respawn request right after a pulse is folded into that pulse.
        respawn_s = respawn_ev_s & ~frog_respawn;
        flash_s   = (state_s == ST_DYING) & timer_s[3];
    end

    // Registered state, counters and outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            timer_r      <= '0;
            frog_respawn <= 1'b0;
            lives        <= 2'(START_LIVES);
            score        <= 16'h0000;
            level        <= 3'd0;
            flash        <= 1'b0;
        end else begin
            state_r      <= state_s;
            timer_r      <= timer_s;
            frog_respawn <= respawn_s;
            lives        <= lives_s;
            score        <= score_s;
            level        <= level_s;
            flash        <= flash_s;
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Testbench for game_ctrl: vector table, directed game sequences and
// randomized stimulus checked against a game-rule reference model.
module tb_game_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        vsync;
    logic        collision;
    logic        reached_end;
    logic [3:0]  dpad_input;
    logic [1:0]  state;
    logic        frog_respawn;
    logic [1:0]  lives;
    logic [15:0] score;
    logic [2:0]  level;
    logic        flash;

    always #5 clk = ~clk;

    game_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .vsync        (vsync),
        .collision    (collision),
        .reached_end  (reached_end),
        .dpad_input   (dpad_input),
        .state        (state),
        .frog_respawn (frog_respawn),
        .lives        (lives),
        .score        (score),
        .level        (level),
        .flash        (flash)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int resp_seen = 0;

    // Reference model: game state in plain integers, score kept in decimal.
    int         m_state;
    int         m_lives;
    int         m_score;
    int         m_level;
    int         m_timer;
    bit         m_resp;
    bit         m_flash;
    bit         p_vs;
    logic [3:0] p_dpad;

    typedef struct {
        logic       vs;
        logic       coll;
        logic       re;
        logic [3:0] dp;
        logic [1:0] st;
        logic       rsp;
        logic [1:0] lv;
        logic [15:0] sc;
        logic [2:0] lvl;
        logic       fl;
    } vec_t;

    vec_t tbl [11];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [31:0] dut_pack();
        return {7'd0, state, frog_respawn, lives, score, level, flash};
    endfunction

    function automatic logic [31:0] exp_pack();
        return {7'd0, 2'(m_state), m_resp, 2'(m_lives), to_bcd(m_score), 3'(m_level), m_flash};
    endfunction

    task automatic model_reset();
        m_state = 0; m_lives = 3; m_score = 0; m_level = 0; m_timer = 0;
        m_resp = 1'b0; m_flash = 1'b0; p_vs = 1'b0; p_dpad = 4'd0;
    endtask

    task automatic load_game();
        m_state = 1; m_lives = 3; m_score = 0; m_level = 0;
    endtask

    // Advance the model by one clock using the inputs presented now.
    task automatic model_clock();
        bit tick, press, ev;
        if (!reset_n) begin
            model_reset();
        end else begin
            tick  = p_vs && !vsync;
            press = (dpad_input != 4'd0) && (p_dpad == 4'd0);
            ev    = 1'b0;
            case (m_state)
                0: if (press) begin load_game(); ev = 1'b1; end
                1: if (tick && collision) begin
                       m_state = 2;
                       m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                       m_timer = 59;
                   end else if (tick && reached_end) begin
                       if (m_score < 9990) m_score += 10;
                       m_level = (m_level < 7) ? m_level + 1 : 7;
                       ev = 1'b1;
                   end
                2: if (tick) begin
                       if (m_timer > 0) m_timer--;
                       else if (m_lives == 0) begin m_state = 3; m_timer = 119; end
                       else begin m_state = 1; ev = 1'b1; end
                   end
                default: if (press && m_timer == 0) begin load_game(); ev = 1'b1; end
                         else if (tick && m_timer > 0) m_timer--;
            endcase
            m_resp  = ev && !m_resp;
            m_flash = (m_state == 2) && (((m_timer / 8) % 2) == 1);
            p_vs    = vsync;
            p_dpad  = dpad_input;
        end
    endtask

    task automatic step();
        model_clock();
        @(posedge clk);
        @(negedge clk);
        if (frog_respawn) resp_seen++;
        check("model", dut_pack(), exp_pack());
    endtask

    task automatic frame(input logic c, input logic r);
        vsync = 1'b1; collision = 1'b0; reached_end = 1'b0; step();
        vsync = 1'b0; collision = c;    reached_end = r;    step();
        collision = 1'b0; reached_end = 1'b0;               step();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame(1'b0, 1'b0);
    endtask

    initial begin
        // vs coll re dp | st rsp lv score lvl fl
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 2'd3, 16'h0000, 3'd0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 4'h4, 2'd1, 1'b1, 2'd3, 16'h0000, 3'd0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 4'h4, 2'd1, 1'b0, 2'd3, 16'h0000, 3'd0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 4'h4, 2'd1, 1'b1, 2'd3, 16'h0010, 3'd1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 4'h0, 2'd1, 1'b0, 2'd3, 16'h0010, 3'd1, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 4'h0, 2'd1, 1'b0, 2'd3, 16'h0010, 3'd1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 4'h0, 2'd1, 1'b0, 2'd3, 16'h0010, 3'd1, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 4'h0, 2'd1, 1'b0, 2'd3, 16'h0010, 3'd1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 4'h0, 2'd2, 1'b0, 2'd2, 16'h0010, 3'd1, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 4'h0, 2'd2, 1'b0, 2'd2, 16'h0010, 3'd1, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 4'h0, 2'd2, 1'b0, 2'd2, 16'h0010, 3'd1, 1'b1};

        reset_n = 1'b0; vsync = 1'b0; collision = 1'b0; reached_end = 1'b0; dpad_input = 4'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_state", dut_pack(), {7'd0, 2'b00, 1'b0, 2'd3, 16'h0000, 3'd0, 1'b0});
        reset_n = 1'b1;

        // Vector table: start press, homes on tick only, collision priority.
        for (int i = 0; i < 11; i++) begin
            vsync = tbl[i].vs; collision = tbl[i].coll;
            reached_end = tbl[i].re; dpad_input = tbl[i].dp;
            step();
            check($sformatf("vec%0d", i), dut_pack(),
                  {7'd0, tbl[i].st, tbl[i].rsp, tbl[i].lv, tbl[i].sc, tbl[i].lvl, tbl[i].fl});
        end
        collision = 1'b0; reached_end = 1'b0;

        // Finish dying (timer now 58): inputs ignored, then one respawn.
        resp_seen = 0;
        for (int i = 0; i < 5; i++) frame(1'b1, 1'b1);
        frames(53);
        check("still_dying", {30'd0, state}, 32'd2);
        frame(1'b0, 1'b0);
        check("dying_to_play", {30'd0, state}, 32'd1);
        check("dying_resp_cnt", resp_seen, 32'd1);

        // Held button produces no further respawn.
        resp_seen = 0;
        dpad_input = 4'h4;
        for (int i = 0; i < 100; i++) step();
        dpad_input = 4'h0; step();
        check("hold_no_resp", resp_seen, 32'd0);

        // Homes, BCD carry, level and score saturation.
        frame(1'b0, 1'b1); frame(1'b0, 1'b1);
        check("score_0030", {16'd0, score}, 32'h0030);
        check("level_3", {29'd0, level}, 32'd3);
        for (int i = 0; i < 96; i++) frame(1'b0, 1'b1);
        check("score_0990", {16'd0, score}, 32'h0990);
        check("level_sat", {29'd0, level}, 32'd7);
        frame(1'b0, 1'b1);
        check("score_1000", {16'd0, score}, 32'h1000);
        for (int i = 0; i < 899; i++) frame(1'b0, 1'b1);
        check("score_9990", {16'd0, score}, 32'h9990);
        frame(1'b0, 1'b1);
        check("score_sat", {16'd0, score}, 32'h9990);

        // Both flags: death wins, score unchanged.
        frame(1'b1, 1'b1);
        check("both_state", {30'd0, state}, 32'd2);
        check("both_lives", {30'd0, lives}, 32'd1);
        check("both_score", {16'd0, score}, 32'h9990);
        frames(60);
        frame(1'b1, 1'b0);
        check("third_death_lives", {30'd0, lives}, 32'd0);
        frames(60);
        check("gameover", {30'd0, state}, 32'd3);

        // Early restart ignored, late restart accepted.
        frames(50);
        dpad_input = 4'h1; step(); dpad_input = 4'h0; step();
        check("early_restart", {30'd0, state}, 32'd3);
        check("go_score_kept", {16'd0, score}, 32'h9990);
        frames(70);
        dpad_input = 4'h2; step();
        check("restart", dut_pack(), {7'd0, 2'b01, 1'b1, 2'd3, 16'h0000, 3'd0, 1'b0});
        dpad_input = 4'h0; step();

        // Asynchronous reset in the middle of DYING.
        frame(1'b1, 1'b0);
        frames(30);
        check("mid_dying", {30'd0, state}, 32'd2);
        reset_n = 1'b0;
        #1;
        check("async_reset", dut_pack(), {7'd0, 2'b00, 1'b0, 2'd3, 16'h0000, 3'd0, 1'b0});
        model_reset();
        @(negedge clk);
        step(); step();
        reset_n = 1'b1;
        frames(10);
        check("idle_after_reset", {30'd0, state}, 32'd0);

        // Randomized play against the model.
        for (int i = 0; i < 4000; i++) begin
            vsync       = 1'($urandom_range(0, 1));
            collision   = ($urandom_range(0, 15) == 0);
            reached_end = ($urandom_range(0, 3) == 0);
            dpad_input  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
